crc_job_sched: RTL

- Schedules CRC jobs from NUM_REQ requesters onto the single shared CRC engine and its memory read port.
- Each requester submits a job as (start address, byte count). The block arbitrates, sequences the memory reads, and feeds bytes to the CRC engine with init/enable strobes.
- Returns the CRC result tagged with the requester ID over a valid/ready handshake.
- Sits between the requester logic and the crc_calc datapath plus its 1024-entry memory.

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_rr_arb.sv | 62 ++++++
 rtl/crc_job_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared types and defaults for the CRC job scheduler (states, widths, CRC seed).
`timescale 1ns/1ps
package crc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DRAIN  = 3'd2,
    CAPT   = 3'd3,
    RESULT = 3'd4
  } crc_sched_state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CRC_W  = 16;

  // Value the CRC engine loads on crc_init.
  localparam logic [DEF_CRC_W-1:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc_rr_arb.sv
// One-hot request arbiter. Round-robin by default; macro CRC_SCHED_PRIO_EN
// selects fixed priority (lowest index wins, no pointer).
`timescale 1ns/1ps
module crc_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_id
);

`ifdef CRC_SCHED_PRIO_EN
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_id     = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;
  logic            w_found;

  // Two passes: indices at/after the pointer first, then the ones below it.
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
        o_gnt[i] = 1'b1;
        o_id     = ID_W'(i);
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i < int'(r_ptr))) begin
        o_gnt[i] = 1'b1;
        o_id     = ID_W'(i);
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (o_id == ID_W'(NUM_REQ - 1)) ? '0 : o_id + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/crc_job_sched.sv
// Schedules (addr, len) CRC jobs from NUM_REQ requesters onto one memory port and
// CRC engine. Arbitration mode chosen in crc_rr_arb via macro CRC_SCHED_PRIO_EN.
`timescale 1ns/1ps
module crc_job_sched
  import crc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CRC_W   = DEF_CRC_W,
  parameter int ID_W    = 2
) (
  input  logic                           clk50m,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][ADDR_W:0]   req_len,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           crc_init,
  output logic                           crc_en,
  output logic [DATA_W-1:0]              crc_din,
  input  logic [CRC_W-1:0]               crc_val,
  output logic                           res_valid,
  output logic [ID_W-1:0]                res_id,
  output logic [CRC_W-1:0]               res_crc,
  input  logic                           res_ready,
  output logic [2:0]                     dbg_state
);

  crc_sched_state_t  r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [ID_W-1:0]   r_id;
  logic              r_crc_en;
  logic              r_res_valid;
  logic [ID_W-1:0]   r_res_id;
  logic [CRC_W-1:0]  r_res_crc;

  logic               w_any;
  logic               w_gnt_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_id;

  // The grant cycle is the IDLE cycle itself, so ack/crc_init are decoded, not registered.
  assign w_any    = |req;
  assign w_gnt_en = (r_state == IDLE) && rst_n && w_any;

  crc_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_clk   (clk50m),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_en    (w_gnt_en),
    .o_gnt   (w_gnt),
    .o_id    (w_gnt_id)
  );

  assign ack       = w_gnt_en ? w_gnt : '0;
  assign crc_init  = w_gnt_en;
  assign busy      = w_gnt_en || (r_state != IDLE);
  assign mem_rd_en = (r_state == READ);
  assign mem_addr  = r_addr;
  assign crc_en    = r_crc_en;
  assign crc_din   = r_crc_en ? mem_rdata : '0;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_crc   = r_res_crc;
  assign dbg_state = r_state;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_crc_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_crc   <= '0;
    end else begin
      // Read data lands one cycle after the strobe, so the engine strobe trails it.
      r_crc_en <= (r_state == READ);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_addr  <= req_addr[w_gnt_id];
            r_cnt   <= req_len[w_gnt_id];
            r_id    <= w_gnt_id;
            r_state <= (req_len[w_gnt_id] != '0) ? READ : CAPT;
          end
        end
        READ: begin
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == (ADDR_W + 1)'(1)) r_state <= DRAIN;
        end
        DRAIN: r_state <= CAPT;
        CAPT: begin
          r_res_crc   <= crc_val;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
